// File: rtl/nor_gate_sequencer.sv
// rtl/nor_gate_sequencer.sv - truth-table sweep and checker for a 3-input NOR gate block
module nor_gate_sequencer #(
    parameter int HOLD_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       d,
    input  logic       e,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] vec;
    logic [7:0] cnt;
    logic       sample;
    logic       expected;
    logic       mismatch;

    // Abort wins over the sample, so a sample is only taken on an un-aborted last hold cycle
    assign sample   = (state == RUN) && !abort && (cnt == LAST_CNT);
    assign expected = (vec == 3'd0);
    assign mismatch = (d != expected) || (e != expected);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (sample && (vec == 3'd7)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All outputs are registered; the gate stimulus is loaded on the same edge that ends a window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 8'd0;
            vec       <= 3'd0;
            cnt       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    {a, b, c} <= 3'b000;
                    done      <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        vec       <= 3'd0;
                        cnt       <= 8'd0;
                        err_count <= 4'd0;
                        fail_vec  <= 8'd0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy      <= 1'b0;
                        {a, b, c} <= 3'b000;
                    end else if (sample) begin
                        if (mismatch) begin
                            fail_vec[vec] <= 1'b1;
                            err_count     <= err_count + 4'd1;
                        end
                        if (vec == 3'd7) begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            {a, b, c} <= 3'b000;
                            pass      <= (err_count == 4'd0) && !mismatch;
                        end else begin
                            vec       <= vec + 3'd1;
                            cnt       <= 8'd0;
                            {a, b, c} <= vec + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    {a, b, c} <= 3'b000;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nor_gate_sequencer.sv
// tb/tb_nor_gate_sequencer.sv - scoreboard bench for nor_gate_sequencer with a fault-injectable gate model
module tb_nor_gate_sequencer;

    localparam int H  = 20;
    localparam int H2 = 2;

    typedef struct {
        logic [7:0] fail;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, d, e, a, b, c, busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;
    logic [7:0] fd, fe;
    logic [2:0] abc_v;

    logic       rst2_n, start2, d2, e2, a2, b2, c2, busy2, done2, pass2;
    logic [3:0] err2;
    logic [7:0] fail2;

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    assign abc_v = {a, b, c};
    // Gate model: a true NOR with per-vector flips on each output
    assign d  = ~(a | b | c) ^ fd[abc_v];
    assign e  = ~(a | b | c) ^ fe[abc_v];
    assign d2 = ~(a2 | b2 | c2);
    assign e2 = ~(a2 | b2 | c2);

    nor_gate_sequencer #(.HOLD_CYCLES(H)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .d(d), .e(e),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    nor_gate_sequencer #(.HOLD_CYCLES(H2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .abort(1'b0), .d(d2), .e(e2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] md, input logic [7:0] me, input int nvec);
        exp_t r;
        r.fail = 8'd0;
        r.err  = 4'd0;
        for (int v = 0; v < nvec; v++) begin
            logic [2:0] vv;
            logic       nor_ref;
            vv      = 3'(v);
            nor_ref = ~(vv[2] | vv[1] | vv[0]);
            if (((nor_ref ^ md[v]) != nor_ref) || ((nor_ref ^ me[v]) != nor_ref)) begin
                r.fail[v] = 1'b1;
                r.err     = r.err + 4'd1;
            end
        end
        r.pass = (nvec == 8) && (r.err == 4'd0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance: vector order, run length, and scoreboard pop on done
    int cyc = 0;
    int last_len = 0;
    always @(negedge clk) begin
        exp_t x;
        if (rst_n === 1'b1) begin
            if (busy) begin
                check("abc_in_run", 32'(abc_v), 32'(cyc / H));
                cyc++;
            end else begin
                if (cyc != 0) last_len = cyc;
                cyc = 0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    x = sb.pop_front();
                    check("pass", 32'(pass), 32'(x.pass));
                    check("err_count", 32'(err_count), 32'(x.err));
                    check("fail_vec", 32'(fail_vec), 32'(x.fail));
                    check("busy_len", 32'(last_len), 32'(8 * H));
                    check("abc_at_done", 32'(abc_v), 32'd0);
                end
            end
        end
    end

    int cyc2 = 0;
    int gap2 = 0;
    int dones2 = 0;
    always @(negedge clk) begin
        if (rst2_n === 1'b1) begin
            if (busy2) begin
                check("abc2_in_run", 32'({a2, b2, c2}), 32'(cyc2 / H2));
                cyc2++;
            end else begin
                cyc2 = 0;
            end
            gap2++;
            if (done2) begin
                check("pass2", 32'(pass2), 32'd1);
                check("err2", 32'(err2), 32'd0);
                if (dones2 > 0) check("done2_period", 32'(gap2), 32'(8 * H2 + 2));
                dones2++;
                gap2 = 0;
            end
        end
    end

    task automatic run_sweep(input logic [7:0] md, input logic [7:0] me, input bit poke);
        int   n;
        int   pk;
        exp_t x;
        n  = 0;
        pk = int'($urandom_range(2, 8 * H - 5));
        fd = md;
        fe = me;
        x  = model(md, me, 8);
        sb.push_back(x);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("abc_after_start", 32'(abc_v), 32'd0);
        while (!done && n < 8 * H + 10) begin
            start = (poke && n == pk);
            tick();
            n++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 32'(done), 32'd1);
        // start while in DONE must not launch a sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_in_done_ignored", 32'(busy), 32'd0);
        tick();
        check("pass_held", 32'(pass), 32'(x.pass));
        check("err_held", 32'(err_count), 32'(x.err));
    endtask

    task automatic wait_vec(input logic [2:0] v);
        int n;
        n = 0;
        while (abc_v != v && n < 8 * H) begin
            tick();
            n++;
        end
        check("reach_vector", 32'(abc_v), 32'(v));
    endtask

    initial begin
        exp_t x;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        abort  = 1'b0;
        fd     = 8'd0;
        fe     = 8'd0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_fail", 32'(fail_vec), 32'd0);
        check("rst_abc", 32'(abc_v), 32'd0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        start2 = 1'b1;

        run_sweep(8'h00, 8'h00, 1'b0);
        run_sweep(8'h00, 8'h01, 1'b0);
        run_sweep(8'h02, 8'h00, 1'b0);
        run_sweep(8'h81, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_sweep(8'($urandom), 8'($urandom & $urandom), 1'b1);
        end

        // Abort during vector 4: only vectors 0..3 have been judged
        fd = 8'($urandom) | 8'h01;
        fe = 8'($urandom);
        x  = model(fd, fe, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(3'd4);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_abc", 32'(abc_v), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_fail_vec", 32'(fail_vec), 32'(x.fail));
        check("abort_err", 32'(err_count), 32'(x.err));
        repeat (8 * H) tick();
        check("abort_no_restart", 32'(busy), 32'd0);

        // Reset pulse during vector 3
        fd = 8'h01;
        fe = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec(3'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pass", 32'(pass), 32'd0);
        check("midrst_err", 32'(err_count), 32'd0);
        check("midrst_fail", 32'(fail_vec), 32'd0);
        check("midrst_abc", 32'(abc_v), 32'd0);
        repeat (8 * H) tick();
        check("midrst_idle", 32'(busy), 32'd0);
        run_sweep(8'h00, 8'h00, 1'b0);

        check("back_to_back_sweeps", 32'(dones2 >= 3), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
